// File: rtl/mnist_layer_sequencer_pkg.sv
// ==== mnist_pkg : shared constants and FSM encoding for the MNIST layer sequencer (rev 1.0) ====
`default_nettype none

package mnist_pkg;

  localparam int N_OUT_DEFAULT = 10;
  localparam int ACT_W         = 32;
  localparam int IDX_W         = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_L1_RUN = 3'd1,
    S_L2_RUN = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mnist_layer_sequencer_if.sv
// ==== mnist_layer_sequencer_if : layer strobes, activations and output stream bundle (rev 1.0) ====
`default_nettype none

interface mnist_layer_sequencer_if
  import mnist_pkg::*;
#(
  parameter int N_OUT  = N_OUT_DEFAULT,
  parameter int DATA_W = ACT_W
);
  logic                      l1_start;
  logic                      l1_done;
  logic                      l2_start;
  logic [N_OUT-1:0]          l2_done_vec;
  logic [N_OUT*DATA_W-1:0]   a_in;
  logic [DATA_W-1:0]         m_tdata;
  logic                      m_tvalid;
  logic                      m_tlast;
  logic                      m_tready;

  modport master (
    output l1_start, l2_start, m_tdata, m_tvalid, m_tlast,
    input  l1_done, l2_done_vec, a_in, m_tready
  );

  modport slave (
    input  l1_start, l2_start, m_tdata, m_tvalid, m_tlast,
    output l1_done, l2_done_vec, a_in, m_tready
  );
endinterface

`default_nettype wire

// File: rtl/mnist_layer_sequencer_argmax_acc.sv
// ==== mnist_argmax_acc : signed running maximum, lowest index wins ties (rev 1.0) ====
`default_nettype none

module mnist_argmax_acc
  import mnist_pkg::*;
#(
  parameter int DATA_W = ACT_W,
  parameter int IDX_W_P = IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               vld,
  input  logic [DATA_W-1:0]  val,
  input  logic [IDX_W_P-1:0] idx,
  output logic [IDX_W_P-1:0] best_idx,
  output logic [DATA_W-1:0]  best_val
);
  logic               have_q, have_d;
  logic [IDX_W_P-1:0] best_idx_q, best_idx_d;
  logic [DATA_W-1:0]  best_val_q, best_val_d;

  always_comb begin
    have_d     = have_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (clr) begin
      have_d     = 1'b0;
      best_idx_d = '0;
      best_val_d = '0;
    end else if (vld && (!have_q || ($signed(val) > $signed(best_val_q)))) begin
      have_d     = 1'b1;
      best_idx_d = idx;
      best_val_d = val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_q     <= 1'b0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      have_q     <= have_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  assign best_idx = best_idx_q;
  assign best_val = best_val_q;

endmodule

`default_nettype wire

// File: rtl/mnist_layer_sequencer.sv
// ==== mnist_layer_sequencer : runs both layers under a watchdog, drains outputs, reports argmax (rev 1.0) ====
`default_nettype none

module mnist_layer_sequencer
  import mnist_pkg::*;
#(
  parameter int N_OUT  = N_OUT_DEFAULT,
  parameter int DATA_W = ACT_W,
  parameter int TMO_W  = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [TMO_W-1:0]        timeout_limit,
  mnist_layer_sequencer_if.master bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic [IDX_W-1:0]        result_class
);
  state_e             state_q, state_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d, wdog_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   result_class_q, result_class_d;
  logic               l1_start_q, l1_start_d;
  logic               l2_start_q, l2_start_d;
  logic [DATA_W-1:0]  snap_q [N_OUT];
  logic [DATA_W-1:0]  snap_d [N_OUT];
  logic [DATA_W-1:0]  beat_data, best_val;
  logic [IDX_W-1:0]   best_idx;
  logic               beat_last, beat_fire, acc_clr, wdog_fire;

  // Saturating count: an all-ones limit must still be reachable.
  assign wdog_inc  = (&wdog_q) ? wdog_q : wdog_q + TMO_W'(1);
  assign wdog_fire = (timeout_limit != '0) && (wdog_inc == timeout_limit);
  assign beat_data = (state_q == S_DRAIN) ? snap_q[idx_q] : '0;
  assign beat_last = (state_q == S_DRAIN) && (idx_q == IDX_W'(N_OUT - 1));
  assign beat_fire = (state_q == S_DRAIN) && bus.m_tready;

  always_comb begin
    state_d        = state_q;
    wdog_d         = wdog_q;
    idx_d          = idx_q;
    result_class_d = result_class_q;
    l1_start_d     = 1'b0;
    l2_start_d     = 1'b0;
    snap_d         = snap_q;
    acc_clr        = 1'b0;
    unique case (state_q)
      // Done levels are only looked at once in the run state, never in IDLE,
      // and a timeout takes priority over a coincident done.
      S_L1_RUN: begin
        wdog_d = wdog_inc;
        if (wdog_fire) begin
          state_d = S_ERR;
        end else if (bus.l1_done) begin
          state_d    = S_L2_RUN;
          l2_start_d = 1'b1;
          wdog_d     = '0;
        end
      end
      S_L2_RUN: begin
        wdog_d = wdog_inc;
        if (wdog_fire) begin
          state_d = S_ERR;
        end else if (&bus.l2_done_vec) begin
          for (int i = 0; i < N_OUT; i++) snap_d[i] = bus.a_in[i*DATA_W +: DATA_W];
          idx_d   = '0;
          acc_clr = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (beat_fire) begin
          idx_d = idx_q + IDX_W'(1);
          if (beat_last) begin
            state_d = S_DONE;
            // Fold in the final beat, which the accumulator has not yet seen.
            result_class_d = ($signed(beat_data) > $signed(best_val)) ? idx_q : best_idx;
          end
        end
      end
      default: begin
        if (start) begin
          state_d    = S_L1_RUN;
          l1_start_d = 1'b1;
          wdog_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q        <= S_IDLE;
      wdog_q         <= '0;
      idx_q          <= '0;
      result_class_q <= '0;
      l1_start_q     <= 1'b0;
      l2_start_q     <= 1'b0;
      for (int i = 0; i < N_OUT; i++) snap_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      wdog_q         <= wdog_d;
      idx_q          <= idx_d;
      result_class_q <= result_class_d;
      l1_start_q     <= l1_start_d;
      l2_start_q     <= l2_start_d;
      snap_q         <= snap_d;
    end
  end

  mnist_argmax_acc #(
    .DATA_W  (DATA_W),
    .IDX_W_P (IDX_W)
  ) u_argmax (
    .clk      (aclk),
    .rst      (areset),
    .clr      (acc_clr),
    .vld      (beat_fire),
    .val      (beat_data),
    .idx      (idx_q),
    .best_idx (best_idx),
    .best_val (best_val)
  );

  assign bus.l1_start  = l1_start_q;
  assign bus.l2_start  = l2_start_q;
  assign bus.m_tdata   = beat_data;
  assign bus.m_tvalid  = (state_q == S_DRAIN);
  assign bus.m_tlast   = beat_last;
  assign busy          = (state_q == S_L1_RUN) || (state_q == S_L2_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign err_timeout   = (state_q == S_ERR);
  assign result_class  = result_class_q;

endmodule

`default_nettype wire
